// File: rtl/mdio_arb_pkg.sv
// Shared types and constants for the MDIO engine arbiter.
// Used by mdio_rr_pick and mdio_arbiter.
package mdio_arb_pkg;

    localparam int MDIO_ADDR_W = 5;
    localparam int MDIO_DATA_W = 16;

    // Read data returned when a transaction is abandoned by the watchdog
    localparam logic [MDIO_DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    // Fold an index in [0, 2n) back into [0, n)
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Combinational round-robin picker: first valid requester
// at or after the pointer, wrapping modulo NREQ.
module mdio_rr_pick
    import mdio_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest valid slot wins
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'(rr_wrap(int'(ptr_i) + k, NREQ));
            if (valid_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO engine among NREQ requesters.
// Optional watchdog enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_arbiter
    import mdio_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ*MDIO_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*MDIO_DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               req_ack,
    output logic [MDIO_DATA_W-1:0]        rsp_rdata,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [MDIO_ADDR_W-1:0]        mdio_addr,
    output logic [MDIO_DATA_W-1:0]        mdio_wr_data,
    output logic                          mdio_rd_request,
    output logic                          mdio_wr_request,
    input  logic                          mdio_ready,
    input  logic [MDIO_DATA_W-1:0]        mdio_rd_data
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mdio_arbiter: unsupported NREQ or TIMEOUT_CYCLES");
    end

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   wr_q, wr_d;
    logic [MDIO_ADDR_W-1:0] addr_q, addr_d;
    logic [MDIO_DATA_W-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic [MDIO_DATA_W-1:0] rdata_q, rdata_d;
    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       grant_nxt;

`ifdef MDIO_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    mdio_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    assign grant_nxt = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    // Next-state: grant, issue, wait for the engine frame, acknowledge
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        rdata_d = rdata_q;
`ifdef MDIO_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mdio_ready && pick_any) begin
                    grant_d = pick_idx;
                    wr_d    = req_write[pick_idx];
                    addr_d  = req_addr[pick_idx*MDIO_ADDR_W +: MDIO_ADDR_W];
                    wdata_d = req_wdata[pick_idx*MDIO_DATA_W +: MDIO_DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
`ifdef MDIO_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_BUSY: begin
                if (!mdio_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mdio_ready) begin
                    ack_d[grant_q] = 1'b1;
                    rdata_d = wr_q ? '0 : mdio_rd_data;
                    ptr_d   = grant_nxt;
                    state_d = IDLE;
`ifdef MDIO_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MDIO_ARB_TIMEOUT_EN
        // A normal completion in the same cycle wins over the watchdog
        if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) &&
            state_d != IDLE) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                ack_d[grant_q] = 1'b1;
                rdata_d = TIMEOUT_RDATA;
                err_d   = 1'b1;
                ptr_d   = grant_nxt;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and transaction registers; reset aborts without an ack
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MDIO_ARB_TIMEOUT_EN
    // Watchdog counter and error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ack         = ack_q;
    assign rsp_rdata       = rdata_q;
    assign busy            = (state_q != IDLE);
    assign mdio_addr       = addr_q;
    assign mdio_wr_data    = wdata_q;
    assign mdio_rd_request = (state_q == ISSUE) && !wr_q;
    assign mdio_wr_request = (state_q == ISSUE) && wr_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter with a behavioural MDIO engine.
// Timeout scenario follows MDIO_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mdio_arbiter;
    import mdio_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ack;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [4:0]  mdio_addr;
    logic [15:0] mdio_wr_data;
    logic        mdio_rd_request;
    logic        mdio_wr_request;
    logic        mdio_ready;
    logic [15:0] mdio_rd_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #200 clock = ~clock;

    mdio_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ack         (req_ack),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .mdio_addr       (mdio_addr),
        .mdio_wr_data    (mdio_wr_data),
        .mdio_rd_request (mdio_rd_request),
        .mdio_wr_request (mdio_wr_request),
        .mdio_ready      (mdio_ready),
        .mdio_rd_data    (mdio_rd_data)
    );

    function automatic logic [15:0] reg_init(input int a);
        return (a == 1) ? 16'h796D : (16'hA500 | 16'(a));
    endfunction

    // Engine model: ready drops 2 cycles after a request, rises 64 later
    logic        eng_rdy = 1'b1;
    logic        eng_active = 1'b0;
    logic        eng_hold = 1'b0;
    logic        eng_hang = 1'b0;
    int          eng_cnt = 0;
    logic [4:0]  eng_addr = '0;
    logic [15:0] eng_rdata = '0;
    logic [15:0] eng_regs [32];

    initial begin
        for (int i = 0; i < 32; i++) eng_regs[i] = reg_init(i);
    end

    always @(posedge clock) begin
        if (mdio_rd_request || mdio_wr_request) begin
            eng_active <= 1'b1;
            eng_cnt    <= 0;
            eng_addr   <= mdio_addr;
            if (mdio_wr_request) eng_regs[mdio_addr] <= mdio_wr_data;
        end else if (eng_active) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 1) eng_rdy <= 1'b0;
            if (eng_cnt == 65 && !eng_hang) begin
                eng_rdy    <= 1'b1;
                eng_active <= 1'b0;
                eng_rdata  <= eng_regs[eng_addr];
            end
        end
    end

    assign mdio_ready   = eng_rdy && !eng_hold;
    assign mdio_rd_data = eng_rdata;

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        sb.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #10 reset_n = 1'b0;
        #10;
        checks++;
        if ({req_ack, rsp_rdata, rsp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got ack=%b rdata=%h err=%b busy=%b, want all 0",
                     req_ack, rsp_rdata, rsp_err, busy);
        end
        checks++;
        if ({mdio_addr, mdio_wr_data, mdio_rd_request, mdio_wr_request} !== '0) begin
            errors++;
            $display("FAIL reset_mdio: got addr=%h wd=%h rd=%b wr=%b, want all 0",
                     mdio_addr, mdio_wr_data, mdio_rd_request, mdio_wr_request);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        exp_t e;
        int   pulses = 0;
        int   grant_cyc = -1;
        int   rise_cyc = -1;
        logic prev_rdy = 1'b1;
        bit   done = 0;
        apply_reset();
        sb.push_back('{0, 1'b0, 5'd1, 16'h0, 16'h796D, 1'b0});
        req_write[0]  = 1'b0;
        req_addr[4:0] = 5'd1;
        req_valid[0]  = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            if (busy && grant_cyc < 0) begin
                grant_cyc = cyc;
                checks++;
                if (mdio_rd_request !== 1'b1) begin
                    errors++;
                    $display("FAIL read_issue: rd_request=%b in first busy cycle, want 1",
                             mdio_rd_request);
                end
            end
            if (mdio_rd_request) begin
                pulses++;
                checks++;
                if (sb.size() == 0 || mdio_addr !== sb[0].addr) begin
                    errors++;
                    $display("FAIL read_addr: got %h, want %h", mdio_addr, 5'd1);
                end
            end
            if (mdio_ready && !prev_rdy) rise_cyc = cyc;
            prev_rdy = mdio_ready;
            if (req_ack != 2'b00) begin
                done = 1;
                req_valid[0] = 1'b0;
                e = sb.pop_front();
                checks++;
                if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL read_ack: got ack=%b rdata=%h err=%b, want ack=%b rdata=%h err=%b",
                             req_ack, rsp_rdata, rsp_err, 2'b01 << e.idx, e.rdata, e.err);
                end
                checks++;
                if (cyc - rise_cyc !== 1) begin
                    errors++;
                    $display("FAIL read_ack_latency: got %0d cycles after ready, want 1",
                             cyc - rise_cyc);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout: no ack within 200 cycles, want ack");
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL read_pulse_width: got %0d rd cycles, want 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        exp_t       e;
        int         acks = 0;
        logic [4:0] prev_addr;
        apply_reset();
        for (int i = 0; i < 4; i++)
            sb.push_back('{i % 2, 1'b0, (i % 2) ? 5'd7 : 5'd3, 16'h0,
                           reg_init((i % 2) ? 7 : 3), 1'b0});
        req_write = 2'b00;
        req_addr  = {5'd7, 5'd3};
        req_valid = 2'b11;
        prev_addr = mdio_addr;
        for (int cyc = 0; cyc < 400 && acks < 4; cyc++) begin
            @(negedge clock);
            if (mdio_addr !== prev_addr) begin
                checks++;
                if (!mdio_rd_request) begin
                    errors++;
                    $display("FAIL rr_addr_stable: addr %h->%h outside a grant, want change only at grant",
                             prev_addr, mdio_addr);
                end
            end
            prev_addr = mdio_addr;
            if (mdio_rd_request) begin
                checks++;
                if (sb.size() == 0 || mdio_addr !== sb[0].addr) begin
                    errors++;
                    $display("FAIL rr_addr: got %h at issue %0d", mdio_addr, acks);
                end
            end
            if (req_ack != 2'b00) begin
                acks++;
                if (acks == 4) req_valid = 2'b00;
                e = sb.pop_front();
                checks++;
                if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got ack=%b rdata=%h, want ack=%b rdata=%h",
                             acks, req_ack, rsp_rdata, 2'b01 << e.idx, e.rdata);
                end
            end
        end
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d acks, want 4", acks);
        end
    endtask

    task automatic test_write();
        exp_t e;
        int   wpulses = 0;
        bit   done = 0;
        sb.push_back('{1, 1'b1, 5'd0, 16'h2100, 16'h0, 1'b0});
        req_write[1]     = 1'b1;
        req_addr[9:5]    = 5'd0;
        req_wdata[31:16] = 16'h2100;
        req_valid        = 2'b10;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            if (mdio_rd_request) begin
                checks++;
                errors++;
                $display("FAIL wr_no_read: rd_request=1 during write, want 0");
            end
            if (mdio_wr_request) begin
                wpulses++;
                checks++;
                if (sb.size() == 0 || mdio_wr_data !== sb[0].wdata || mdio_addr !== sb[0].addr) begin
                    errors++;
                    $display("FAIL wr_data: got addr=%h data=%h, want addr=00 data=2100",
                             mdio_addr, mdio_wr_data);
                end
                checks++;
                if (rsp_rdata !== reg_init(7)) begin
                    errors++;
                    $display("FAIL rdata_hold: got %h before ack, want %h", rsp_rdata, reg_init(7));
                end
            end
            if (req_ack != 2'b00) begin
                done = 1;
                req_valid = 2'b00;
                req_write = 2'b00;
                e = sb.pop_front();
                checks++;
                if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL wr_ack: got ack=%b rdata=%h err=%b, want ack=10 rdata=0000 err=0",
                             req_ack, rsp_rdata, rsp_err);
                end
            end
        end
        checks++;
        if (!done || wpulses !== 1) begin
            errors++;
            $display("FAIL wr_done: got done=%0d wr_pulses=%0d, want 1 and 1", done, wpulses);
        end
    endtask

    task automatic test_busy_after_reset();
        exp_t e;
        int   pulses = 0;
        int   busy_cyc = 0;
        bit   done = 0;
        eng_hold = 1'b1;
        apply_reset();
        req_write[0]  = 1'b0;
        req_addr[4:0] = 5'd2;
        req_valid[0]  = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (mdio_rd_request || mdio_wr_request) pulses++;
            if (busy) busy_cyc++;
        end
        checks++;
        if (pulses !== 0 || busy_cyc !== 0) begin
            errors++;
            $display("FAIL busy_engine_grant: got pulses=%0d busy=%0d while ready=0, want 0 and 0",
                     pulses, busy_cyc);
        end
        sb.push_back('{0, 1'b0, 5'd2, 16'h0, reg_init(2), 1'b0});
        eng_hold = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            if (req_ack != 2'b00) begin
                done = 1;
                req_valid = 2'b00;
                e = sb.pop_front();
                checks++;
                if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL busy_engine_ack: got ack=%b rdata=%h, want ack=01 rdata=%h",
                             req_ack, rsp_rdata, e.rdata);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL busy_engine_done: no ack after ready, want ack");
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   wait_done = 0;
        bit   rdy_seen = 0;
        bit   done = 0;
        req_write[0]  = 1'b0;
        req_addr[4:0] = 5'd5;
        req_valid[0]  = 1'b1;
        for (int cyc = 0; cyc < 100 && wait_done < 10; cyc++) begin
            @(negedge clock);
            if (busy && !mdio_ready) wait_done++;
        end
        #50 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ack, rsp_rdata, busy, mdio_addr, mdio_rd_request} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got ack=%b rdata=%h busy=%b addr=%h rd=%b, want all 0",
                     req_ack, rsp_rdata, busy, mdio_addr, mdio_rd_request);
        end
        sb.delete();
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (req_ack !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_hold: got ack=%b busy=%b in reset, want 00 0", req_ack, busy);
            end
        end
        reset_n = 1'b1;
        sb.push_back('{0, 1'b0, 5'd5, 16'h0, reg_init(5), 1'b0});
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            if (mdio_ready) rdy_seen = 1;
            if (mdio_rd_request) begin
                checks++;
                if (!rdy_seen) begin
                    errors++;
                    $display("FAIL midreset_early: rd_request before engine ready, want wait");
                end
            end
            if (req_ack != 2'b00) begin
                done = 1;
                req_valid = 2'b00;
                e = sb.pop_front();
                checks++;
                if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL midreset_ack: got ack=%b rdata=%h, want ack=01 rdata=%h",
                             req_ack, rsp_rdata, e.rdata);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL midreset_resume: no ack after release, want ack");
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   acks = 0;
        int   rd_cyc = -1;
        eng_hang = 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
        sb.push_back('{0, 1'b0, 5'd1, 16'h0, TIMEOUT_RDATA, 1'b1});
`endif
        req_write[0]  = 1'b0;
        req_addr[4:0] = 5'd1;
        req_valid[0]  = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            if (mdio_rd_request) rd_cyc = cyc;
            if (req_ack != 2'b00) begin
                acks++;
                req_valid = 2'b00;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL timeout_unexpected_ack: got ack=%b, want none", req_ack);
                end else begin
                    e = sb.pop_front();
                    if (req_ack !== (2'b01 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL timeout_ack: got ack=%b rdata=%h err=%b, want ack=01 rdata=ffff err=1",
                                 req_ack, rsp_rdata, rsp_err);
                    end
                    // issue cycle, then TMO wait cycles, then the ack cycle
                    checks++;
                    if (cyc - rd_cyc !== TMO + 1) begin
                        errors++;
                        $display("FAIL timeout_latency: got %0d, want %0d", cyc - rd_cyc, TMO + 1);
                    end
                end
            end
        end
        checks++;
`ifdef MDIO_ARB_TIMEOUT_EN
        if (acks !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d acks, want 1", acks);
        end
`else
        if (acks !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: got acks=%0d busy=%b, want 0 and 1", acks, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_busy_after_reset();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
